pc_stack_unit: RTL and testbench

- Parametrised program-counter unit; the next generation of the CPU's 6-bit PC register.
- Adds increment, PC-relative branch, absolute jump, and call/return through an internal return-address stack of configurable depth.
- Adds a sticky fault flag for stack overflow/underflow.
- Sits between the control unit, which supplies run and op, and instruction memory, which is addressed by pc.

---
 rtl/pc_stack_unit.sv | 91 +++++++++
 tb/tb_pc_stack_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program-counter unit with increment, relative branch, absolute jump and
// call/return through a small return-address stack with a sticky fault flag.
module pc_stack_unit #(
   parameter int WIDTH        = 6,
   parameter int RESET_VECTOR = 32,
   parameter int OFFSET_WIDTH = 6,
   parameter int STACK_DEPTH  = 4
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               run,
   input  logic [2:0]                         op,
   input  logic [OFFSET_WIDTH-1:0]            offset,
   input  logic [WIDTH-1:0]                   target,
   output logic [WIDTH-1:0]                   pc,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
   output logic                               stack_full,
   output logic                               stack_empty,
   output logic                               fault
);

   localparam int SPW  = $clog2(STACK_DEPTH + 1);
   localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [2:0] {
      OP_HOLD   = 3'd0,
      OP_INC    = 3'd1,
      OP_BRANCH = 3'd2,
      OP_JUMP   = 3'd3,
      OP_CALL   = 3'd4,
      OP_RET    = 3'd5
   } op_e;

   logic [WIDTH-1:0] stack [STACK_DEPTH];
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] offset_ext;
   logic [SPW-1:0]   sp_dec;
   logic [IDXW-1:0]  wr_idx;
   logic [IDXW-1:0]  rd_idx;
   logic             push;

   assign pc_inc      = pc + WIDTH'(1);
   assign offset_ext  = WIDTH'($signed(offset));
   assign sp_dec      = sp - SPW'(1);
   assign wr_idx      = sp[IDXW-1:0];
   assign rd_idx      = sp_dec[IDXW-1:0];
   assign stack_full  = (sp == SPW'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   assign push        = !reset && run && !fault && (op == OP_CALL) && !stack_full;

   // A raised fault halts everything until reset, so the advance gate covers it.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc    <= WIDTH'(RESET_VECTOR);
         sp    <= '0;
         fault <= 1'b0;
      end else if (run && !fault) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of pc and sp.
         case (op)
            OP_INC:    pc <= pc_inc;
            OP_BRANCH: pc <= pc_inc + offset_ext;
            OP_JUMP:   pc <= target;
            OP_CALL: begin
               if (stack_full) begin
                  fault <= 1'b1;
               end else begin
                  sp <= sp + SPW'(1);
                  pc <= target;
               end
            end
            OP_RET: begin
               if (stack_empty) begin
                  fault <= 1'b1;
               end else begin
                  sp <= sp_dec;
                  pc <= stack[rd_idx];
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the stack array is deliberately not reset; sp == 0 after reset
   // means no stale entry can ever be read.
   always_ff @(posedge clock) begin
      if (push) stack[wr_idx] <= pc_inc;
   end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: a behavioural model pushes expected state
// into a scoreboard queue, popped and compared one cycle after each step.
module tb_pc_stack_unit;

   localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, BRANCH = 3'd2,
                          JUMP = 3'd3, CALL = 3'd4, RET = 3'd5;

   logic       clock = 1'b0;
   logic       reset, run;
   logic [2:0] op;
   logic [5:0] offset, target;
   logic [5:0] pc;
   logic [2:0] sp;
   logic       stack_full, stack_empty, fault;

   typedef struct {
      string      tag;
      logic [5:0] pc;
      logic [2:0] sp;
      logic       full;
      logic       empty;
      logic       fault;
   } exp_t;

   exp_t sb[$];
   int   n_asserts = 0;
   int   n_fails   = 0;

   int         m_pc = 0, m_sp = 0, m_fault = 0;
   logic [5:0] m_stack [4];

   pc_stack_unit #(
      .WIDTH(6), .RESET_VECTOR(32), .OFFSET_WIDTH(6), .STACK_DEPTH(4)
   ) dut (
      .clock(clock), .reset(reset), .run(run), .op(op), .offset(offset),
      .target(target), .pc(pc), .sp(sp), .stack_full(stack_full),
      .stack_empty(stack_empty), .fault(fault)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_asserts++;
      assert (obs === exp_v) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic model(input logic rst, input logic r, input logic [2:0] o,
                        input logic [5:0] off, input logic [5:0] tgt);
      int so;
      if (rst) begin
         m_pc = 32; m_sp = 0; m_fault = 0;
      end else if (r && m_fault == 0) begin
         case (o)
            INC:    m_pc = (m_pc + 1) % 64;
            BRANCH: begin
               so   = off[5] ? int'(off) - 64 : int'(off);
               m_pc = (m_pc + 1 + so + 128) % 64;
            end
            JUMP:   m_pc = int'(tgt);
            CALL: begin
               if (m_sp == 4) m_fault = 1;
               else begin
                  m_stack[m_sp] = 6'((m_pc + 1) % 64);
                  m_sp++;
                  m_pc = int'(tgt);
               end
            end
            RET: begin
               if (m_sp == 0) m_fault = 1;
               else begin
                  m_sp--;
                  m_pc = int'(m_stack[m_sp]);
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic r,
                       input logic [2:0] o, input logic [5:0] off, input logic [5:0] tgt);
      exp_t e;
      reset = rst; run = r; op = o; offset = off; target = tgt;
      model(rst, r, o, off, tgt);
      e.tag = tag; e.pc = 6'(m_pc); e.sp = 3'(m_sp);
      e.full = (m_sp == 4); e.empty = (m_sp == 0); e.fault = (m_fault != 0);
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      check({e.tag, ".pc"},    8'(pc),          8'(e.pc));
      check({e.tag, ".sp"},    8'(sp),          8'(e.sp));
      check({e.tag, ".full"},  8'(stack_full),  8'(e.full));
      check({e.tag, ".empty"}, 8'(stack_empty), 8'(e.empty));
      check({e.tag, ".fault"}, 8'(fault),       8'(e.fault));
   endtask

   initial begin
      // Reset wins over run=0 with a pending JUMP.
      step("reset0", 1, 0, JUMP, 0, 5);
      check("plan.reset_pc", 8'(pc), 8'd32);
      check("plan.reset_empty", 8'(stack_empty), 8'd1);

      step("jump62", 0, 1, JUMP, 0, 62);
      step("inc63",  0, 1, INC, 0, 0);
      check("plan.inc63", 8'(pc), 8'd63);
      step("inc_wrap", 0, 1, INC, 0, 0);
      check("plan.inc_wrap", 8'(pc), 8'd0);
      for (int i = 0; i < 3; i++) step("frozen", 0, 0, INC, 0, 0);
      check("plan.frozen", 8'(pc), 8'd0);

      step("hold0", 0, 1, HOLD, 0, 0);
      step("hold6", 0, 1, 3'd6, 0, 7);
      step("hold7", 0, 1, 3'd7, 0, 7);

      step("jump10", 0, 1, JUMP, 0, 10);
      step("br_neg", 0, 1, BRANCH, 6'b111101, 0);
      check("plan.br_neg", 8'(pc), 8'd8);
      step("jump40", 0, 1, JUMP, 0, 40);
      step("br_wrap", 0, 1, BRANCH, 6'd31, 0);
      check("plan.br_wrap", 8'(pc), 8'd8);
      step("br_min", 0, 1, BRANCH, 6'b100000, 0);

      step("jump33", 0, 1, JUMP, 0, 33);
      step("call5",  0, 1, CALL, 0, 5);
      step("call20", 0, 1, CALL, 0, 20);
      step("ret6",   0, 1, RET, 0, 0);
      check("plan.ret6", 8'(pc), 8'd6);
      step("ret34",  0, 1, RET, 0, 0);
      check("plan.ret34", 8'(pc), 8'd34);

      // Back-to-back call/return around the top of the address space.
      step("jump63", 0, 1, JUMP, 0, 63);
      step("call_w", 0, 1, CALL, 0, 12);
      step("ret_w",  0, 1, RET, 0, 0);
      check("plan.ret_wrap", 8'(pc), 8'd0);

      step("call_a", 0, 1, CALL, 0, 1);
      step("call_b", 0, 1, CALL, 0, 2);
      step("call_c", 0, 1, CALL, 0, 3);
      step("call_d", 0, 1, CALL, 0, 4);
      check("plan.full", 8'(stack_full), 8'd1);
      step("overflow", 0, 1, CALL, 0, 9);
      check("plan.ovf_fault", 8'(fault), 8'd1);
      check("plan.ovf_pc", 8'(pc), 8'd4);
      step("halt_inc",  0, 1, INC, 0, 0);
      step("halt_jump", 0, 1, JUMP, 0, 17);
      step("halt_ret",  0, 1, RET, 0, 0);
      step("reset1", 1, 1, INC, 0, 0);
      check("plan.reset1_fault", 8'(fault), 8'd0);

      step("underflow", 0, 1, RET, 0, 0);
      check("plan.udf_pc", 8'(pc), 8'd32);
      check("plan.udf_fault", 8'(fault), 8'd1);
      step("reset_call", 1, 1, CALL, 0, 9);
      check("plan.reset_call_sp", 8'(sp), 8'd0);

      step("post_call", 0, 1, CALL, 0, 50);
      step("post_ret",  0, 1, RET, 0, 0);
      check("plan.post_ret", 8'(pc), 8'd33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
